// File: rtl/uart_sipo_rx.sv
// ============================================================================
// Module   : uart_sipo_rx
// Brief    : Oversampling UART receiver (start, 8 data LSB first, parity,
//            stop) with valid/ack delivery, parity/framing/overrun status.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_sipo_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       baud_clock,
    input  logic       reset_n,
    input  logic       serial_in,
    input  logic       parity_odd,
    input  logic       data_ack,
    output logic [7:0] parallel_data,
    output logic       data_valid,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun_error,
    output logic       is_receiving
);

    localparam int CW = $clog2(OVERSAMPLE);

    // Phase positions inside one bit period (phase 0 = detection-aligned).
    localparam logic [CW-1:0] c_PH_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] c_PH_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] c_PH_DEC  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] c_PH_LAST = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_DATA      = 3'd2;
    localparam logic [2:0] c_ST_PARITY    = 3'd3;
    localparam logic [2:0] c_ST_STOP      = 3'd4;
    localparam logic [2:0] c_ST_WAIT_IDLE = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_rx_prev;
    logic [CW-1:0] r_phase;
    logic          r_s0;
    logic          r_s1;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_par_err;

    logic          w_rx;
    logic          w_maj;
    logic          w_decide;
    logic          w_start_det;
    logic          w_start_ok;
    logic          w_shift;
    logic          w_par_chk;
    logic          w_complete;

    assign w_rx  = r_sync2;
    assign w_maj = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge baud_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= serial_in;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Bit-phase counter, realigned so the detection cycle is phase 0.
    always_ff @(posedge baud_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (w_start_det) begin
            r_phase <= CW'(1);
        end else if (r_phase == c_PH_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + CW'(1);
        end
    end

    // Capture the two samples preceding the decision tick for the vote.
    always_ff @(posedge baud_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_phase == c_PH_S0) r_s0 <= w_rx;
            if (r_phase == c_PH_S1) r_s1 <= w_rx;
        end
    end

    // State register.
    always_ff @(posedge baud_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; frame states advance only on a decision tick.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:      if (!w_rx && r_rx_prev) w_state_nxt = c_ST_START;
            c_ST_START:     if (w_decide) w_state_nxt = w_maj ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:      if (w_decide && (r_bitcnt == 3'd7)) w_state_nxt = c_ST_PARITY;
            c_ST_PARITY:    if (w_decide) w_state_nxt = c_ST_STOP;
            c_ST_STOP:      if (w_decide) w_state_nxt = w_maj ? c_ST_IDLE : c_ST_WAIT_IDLE;
            c_ST_WAIT_IDLE: if (w_rx) w_state_nxt = c_ST_IDLE;
            default:        w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Per-state strobes consumed by the datapath.
    always_comb begin
        w_decide    = 1'b0;
        w_start_det = 1'b0;
        w_start_ok  = 1'b0;
        w_shift     = 1'b0;
        w_par_chk   = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            c_ST_IDLE:   w_start_det = !w_rx && r_rx_prev;
            c_ST_START: begin
                w_decide   = (r_phase == c_PH_DEC);
                w_start_ok = w_decide && !w_maj;
            end
            c_ST_DATA: begin
                w_decide = (r_phase == c_PH_DEC);
                w_shift  = w_decide;
            end
            c_ST_PARITY: begin
                w_decide  = (r_phase == c_PH_DEC);
                w_par_chk = w_decide;
            end
            c_ST_STOP: begin
                w_decide   = (r_phase == c_PH_DEC);
                w_complete = w_decide;
            end
            default: ;
        endcase
    end

    // Shift register, data bit counter, parity check and receiving flag.
    always_ff @(posedge baud_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt     <= 3'd0;
            r_shift      <= 8'h00;
            r_par_err    <= 1'b0;
            is_receiving <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_bitcnt <= 3'd0;
            end else if (w_shift) begin
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_shift) begin
                r_shift <= {w_maj, r_shift[7:1]};
            end
            if (w_par_chk) begin
                r_par_err <= w_maj ^ (^r_shift) ^ parity_odd;
            end
            if (w_start_ok) begin
                is_receiving <= 1'b1;
            end else if (w_complete) begin
                is_receiving <= 1'b0;
            end
        end
    end

    // Delivery and handshake; a completed frame is dropped if the old byte is unacked.
    always_ff @(posedge baud_clock or negedge reset_n) begin
        if (!reset_n) begin
            parallel_data <= 8'h00;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else if (w_complete) begin
            if (!data_valid || data_ack) begin
                parallel_data <= r_shift;
                parity_error  <= r_par_err;
                framing_error <= !w_maj;
                data_valid    <= 1'b1;
                overrun_error <= 1'b0;
            end else begin
                overrun_error <= 1'b1;
            end
        end else if (data_ack && data_valid) begin
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_sipo_rx.sv
// ============================================================================
// Module   : tb_uart_sipo_rx
// Brief    : Directed self-checking bench for uart_sipo_rx.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_sipo_rx;

    localparam int OS = 16;

    logic       baud_clock = 1'b0;
    logic       reset_n    = 1'b0;
    logic       serial_in  = 1'b1;
    logic       parity_odd = 1'b0;
    logic       data_ack   = 1'b0;
    logic [7:0] parallel_data;
    logic       data_valid;
    logic       parity_error;
    logic       framing_error;
    logic       overrun_error;
    logic       is_receiving;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int fall_cyc  = 0;
    int rise_cyc  = -1;
    logic last_dv    = 1'b0;
    logic recv_seen  = 1'b0;

    uart_sipo_rx #(.OVERSAMPLE(OS)) dut (
        .baud_clock    (baud_clock),
        .reset_n       (reset_n),
        .serial_in     (serial_in),
        .parity_odd    (parity_odd),
        .data_ack      (data_ack),
        .parallel_data (parallel_data),
        .data_valid    (data_valid),
        .parity_error  (parity_error),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .is_receiving  (is_receiving)
    );

    always #5 baud_clock = ~baud_clock;

    always @(posedge baud_clock) cyc <= cyc + 1;

    // Track data_valid rising time and any is_receiving activity.
    always @(negedge baud_clock) begin
        if (data_valid && !last_dv) rise_cyc = cyc;
        last_dv = data_valid;
        if (is_receiving) recv_seen = 1'b1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge baud_clock);
            #1;
        end
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        @(posedge baud_clock);
        #1;
        data_ack = 1'b0;
    endtask

    // Drive one frame cycle by cycle; optional glitch, ack or reset at a cycle offset.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input int glitch, input int ack_at, input int abort_at);
        logic [10:0] fr;
        logic        b;
        fr = {sbit, pbit, d, 1'b0};
        for (int j = 0; j < 11 * OS; j++) begin
            if (j == abort_at) begin
                reset_n = 1'b0;
                #1;
                return;
            end
            b = fr[j / OS];
            if (j == glitch) b = ~b;
            serial_in = b;
            data_ack  = (j == ack_at);
            if (j == 0) fall_cyc = cyc;
            @(posedge baud_clock);
            #1;
        end
        data_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        n_total++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_valid); else n_pass++;
        n_total++; if (parallel_data !== 8'h00) $display("FAIL reset_data: got %h want 00", parallel_data); else n_pass++;
        n_total++; if ({parity_error, framing_error, overrun_error, is_receiving} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {parity_error, framing_error, overrun_error, is_receiving}); else n_pass++;
        reset_n = 1'b1;
        idle(5);
    endtask

    task automatic test_basic();
        rise_cyc = -1;
        send_frame(8'hA5, 1'b0, 1'b1, -1, -1, -1);
        n_total++; if ((rise_cyc - fall_cyc) !== 172) $display("FAIL basic_latency: got %0d want 172", rise_cyc - fall_cyc); else n_pass++;
        n_total++; if (parallel_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", parallel_data); else n_pass++;
        n_total++; if ({parity_error, framing_error} !== 2'b00) $display("FAIL basic_errs: got %b want 00", {parity_error, framing_error}); else n_pass++;
        data_ack = 1'b1;
        @(negedge baud_clock);
        n_total++; if (data_valid !== 1'b1) $display("FAIL ack_same_cycle: got %b want 1", data_valid); else n_pass++;
        @(posedge baud_clock);
        #1;
        data_ack = 1'b0;
        n_total++; if (data_valid !== 1'b0) $display("FAIL ack_clear: got %b want 0", data_valid); else n_pass++;
        idle(8);
    endtask

    task automatic test_parity();
        parity_odd = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1, -1);
        n_total++; if (parity_error !== 1'b1) $display("FAIL par_even_err: got %b want 1", parity_error); else n_pass++;
        n_total++; if (parallel_data !== 8'h3C) $display("FAIL par_even_data: got %h want 3c", parallel_data); else n_pass++;
        pulse_ack();
        n_total++; if (parity_error !== 1'b0) $display("FAIL par_clear: got %b want 0", parity_error); else n_pass++;
        idle(8);
        parity_odd = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1, -1);
        n_total++; if ({data_valid, parity_error} !== 2'b10) $display("FAIL par_odd_ok: got %b want 10", {data_valid, parity_error}); else n_pass++;
        pulse_ack();
        parity_odd = 1'b0;
        idle(8);
    endtask

    task automatic test_framing();
        send_frame(8'h81, 1'b0, 1'b0, -1, -1, -1);
        n_total++; if (framing_error !== 1'b1) $display("FAIL frame_err: got %b want 1", framing_error); else n_pass++;
        n_total++; if (parallel_data !== 8'h81) $display("FAIL frame_data: got %h want 81", parallel_data); else n_pass++;
        pulse_ack();
        recv_seen = 1'b0;
        idle(40 * OS - OS);
        n_total++; if ({data_valid, recv_seen} !== 2'b00) $display("FAIL break_quiet: got %b want 00", {data_valid, recv_seen}); else n_pass++;
        serial_in = 1'b1;
        idle(2 * OS);
        send_frame(8'h55, 1'b0, 1'b1, -1, -1, -1);
        n_total++; if ({data_valid, parallel_data, parity_error, framing_error} !== {1'b1, 8'h55, 2'b00})
            $display("FAIL after_break: got %b_%h_%b want 1_55_00", data_valid, parallel_data, {parity_error, framing_error}); else n_pass++;
        pulse_ack();
        idle(8);
    endtask

    task automatic test_glitch();
        recv_seen = 1'b0;
        serial_in = 1'b0;
        idle(4);
        serial_in = 1'b1;
        idle(200);
        n_total++; if ({data_valid, recv_seen} !== 2'b00) $display("FAIL false_start: got %b want 00", {data_valid, recv_seen}); else n_pass++;
        send_frame(8'h00, 1'b0, 1'b1, 56, -1, -1);
        n_total++; if ({data_valid, parallel_data, parity_error} !== {1'b1, 8'h00, 1'b0})
            $display("FAIL glitch_vote: got %b_%h_%b want 1_00_0", data_valid, parallel_data, parity_error); else n_pass++;
        pulse_ack();
        idle(8);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b0, 1'b1, -1, -1, -1);
        send_frame(8'h22, 1'b0, 1'b1, -1, -1, -1);
        n_total++; if ({data_valid, parallel_data, overrun_error} !== {1'b1, 8'h11, 1'b1})
            $display("FAIL overrun: got %b_%h_%b want 1_11_1", data_valid, parallel_data, overrun_error); else n_pass++;
        pulse_ack();
        n_total++; if ({data_valid, overrun_error} !== 2'b00) $display("FAIL overrun_clear: got %b want 00", {data_valid, overrun_error}); else n_pass++;
        idle(8);
        send_frame(8'h11, 1'b0, 1'b1, -1, -1, -1);
        send_frame(8'h22, 1'b0, 1'b1, -1, 171, -1);
        n_total++; if ({data_valid, parallel_data, overrun_error} !== {1'b1, 8'h22, 1'b0})
            $display("FAIL ack_and_complete: got %b_%h_%b want 1_22_0", data_valid, parallel_data, overrun_error); else n_pass++;
        idle(8);
    endtask

    task automatic test_mid_reset();
        send_frame(8'hF0, 1'b0, 1'b1, -1, -1, 5 * OS + 8);
        n_total++; if ({data_valid, parallel_data, parity_error, framing_error, overrun_error, is_receiving} !== 13'd0)
            $display("FAIL mid_reset: got %b_%h_%b want 0_00_0000", data_valid, parallel_data,
                     {parity_error, framing_error, overrun_error, is_receiving}); else n_pass++;
        serial_in = 1'b1;
        idle(4);
        reset_n = 1'b1;
        idle(20);
        send_frame(8'h0F, 1'b0, 1'b1, -1, -1, -1);
        n_total++; if ({data_valid, parallel_data, parity_error, framing_error} !== {1'b1, 8'h0F, 2'b00})
            $display("FAIL after_reset: got %b_%h_%b want 1_0f_00", data_valid, parallel_data, {parity_error, framing_error}); else n_pass++;
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_framing();
        test_glitch();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
